// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: request encodings
// and default operation latencies.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mul_div_unit_arith.sv
// Combinational datapath: 32x32 multiply and 32/32 divide producing HI/LO
// results plus a divide-by-zero flag.
module md_arith
    import mul_div_unit_pkg::*;
(
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    input  md_op_e      op_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        div_by_zero_o
);

    logic        signed_mul;
    logic        signed_div;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        signed_mul = (op_i == MD_MULT);
        signed_div = (op_i == MD_DIV);

        // Sign-extended 64-bit product is exact modulo 2^64 for both signednesses.
        prod = {{32{signed_mul & rs_val_i[31]}}, rs_val_i}
             * {{32{signed_mul & rt_val_i[31]}}, rt_val_i};

        // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
        a_mag = (signed_div && rs_val_i[31]) ? (~rs_val_i + 32'd1) : rs_val_i;
        b_mag = (signed_div && rt_val_i[31]) ? (~rt_val_i + 32'd1) : rt_val_i;
        div_b = (rt_val_i == '0) ? 32'd1 : b_mag;
        q_mag = a_mag / div_b;
        r_mag = a_mag % div_b;
        quot  = (signed_div && (rs_val_i[31] ^ rt_val_i[31])) ? (~q_mag + 32'd1) : q_mag;
        rem   = (signed_div && rs_val_i[31]) ? (~r_mag + 32'd1) : r_mag;

        res_hi_o      = '0;
        res_lo_o      = '0;
        div_by_zero_o = 1'b0;
        case (op_i)
            MD_MULT, MD_MULTU: begin
                res_hi_o = prod[63:32];
                res_lo_o = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_hi_o      = rem;
                res_lo_o      = quot;
                div_by_zero_o = (rt_val_i == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; results are held pending
// and committed when the latency down-counter expires.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic        kill,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    md_op_e      op;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_dbz;
    logic        accept;

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        dbz_q, dbz_d;
    logic        busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;

    assign op = md_op_e'(md_op);

    md_arith u_arith (
        .rs_val_i      (rs_val),
        .rt_val_i      (rt_val),
        .op_i          (op),
        .res_hi_o      (res_hi),
        .res_lo_o      (res_lo),
        .div_by_zero_o (res_dbz)
    );

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        dbz_d     = dbz_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;

        accept = !kill && !busy_q && (op != MD_NONE) && (op != MD_RSVD);

        if (busy_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                if (!dbz_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (accept) begin
            case (op)
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    dbz_d     = res_dbz;
                    busy_d    = 1'b1;
                    cnt_d     = (op == MD_DIV || op == MD_DIVU) ? DIV_LOAD : MULT_LOAD;
                end
                MD_MTHI: hi_d = rs_val;
                MD_MTLO: lo_d = rs_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: per-cycle comparison against an
// arithmetic reference model plus literal checkpoints from worked examples.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  md_op = 3'd0;
    logic        kill = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .md_op  (md_op),
        .kill   (kill),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Reference model: remaining busy cycles plus the result waiting to land.
    int unsigned m_left = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_phi = '0;
    logic [31:0] m_plo = '0;
    bit          m_dz = 1'b0;

    always @(posedge clk) begin
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(rs_val));
        sb = longint'($signed(rt_val));
        ua = {32'd0, rs_val};
        ub = {32'd0, rt_val};
        if (reset) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_dz = 1'b0;
        end else if (m_left != 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && !m_dz) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (!kill) begin
            case (md_op)
                3'd1: begin
                    sq = sa * sb; m_phi = sq[63:32]; m_plo = sq[31:0]; m_dz = 1'b0; m_left = 5;
                end
                3'd2: begin
                    up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0]; m_dz = 1'b0; m_left = 5;
                end
                3'd3: begin
                    m_dz = (rt_val == 0); m_left = 10;
                    if (!m_dz) begin
                        sq = sa / sb; sr = sa % sb; m_plo = sq[31:0]; m_phi = sr[31:0];
                    end
                end
                3'd4: begin
                    m_dz = (rt_val == 0); m_left = 10;
                    if (!m_dz) begin
                        up = ua / ub; m_plo = up[31:0]; up = ua % ub; m_phi = up[31:0];
                    end
                end
                3'd5: m_hi = rs_val;
                3'd6: m_lo = rs_val;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, then compare DUT against the model mid-cycle.
    task automatic cyc(input logic [2:0] op, input logic k, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
        md_op = op; kill = k; rs_val = a; rt_val = b; reset = r;
        @(posedge clk);
        #5;
        chk("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic idle();
        cyc(3'd0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_idle(input string name, input int exp_cycles);
        int n = 0;
        while (busy && n < 40) begin
            idle();
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: busy still high after %0d cycles", name, n);
        end
        chk({name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        cyc(3'd0, 1'b0, '0, '0, 1'b1);
        cyc(3'd0, 1'b0, '0, '0, 1'b1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);

        cyc(3'd1, 1'b0, 32'hFFFFFFFF, 32'h2, 1'b0);
        wait_idle("mult", 5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);

        cyc(3'd2, 1'b0, 32'hFFFFFFFF, 32'h2, 1'b0);
        wait_idle("multu", 5);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        cyc(3'd3, 1'b0, 32'hFFFFFFF9, 32'h2, 1'b0);
        wait_idle("div", 10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        cyc(3'd3, 1'b0, 32'h7, 32'hFFFFFFFE, 1'b0);
        wait_idle("div_negdiv", 10);
        chk("div_negdiv_lo", lo, 32'hFFFFFFFD);
        chk("div_negdiv_hi", hi, 32'h00000001);

        cyc(3'd3, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle("div_ovf", 10);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h00000000);

        cyc(3'd4, 1'b0, 32'd100, 32'd7, 1'b0);
        wait_idle("divu", 10);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        cyc(3'd5, 1'b0, 32'h12345678, 32'h0, 1'b0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_lo_kept", lo, 32'd14);
        cyc(3'd6, 1'b0, 32'h9ABCDEF0, 32'h0, 1'b0);
        cyc(3'd4, 1'b0, 32'h5, 32'h0, 1'b0);
        wait_idle("divz", 10);
        chk("divz_hi", hi, 32'h12345678);
        chk("divz_lo", lo, 32'h9ABCDEF0);

        cyc(3'd1, 1'b1, 32'h3, 32'h4, 1'b0);
        chk("kill_busy", {31'd0, busy}, 32'd0);
        idle();
        chk("kill_hi", hi, 32'h12345678);
        chk("kill_lo", lo, 32'h9ABCDEF0);

        cyc(3'd7, 1'b0, 32'hAAAA5555, 32'h1, 1'b0);
        chk("rsvd_busy", {31'd0, busy}, 32'd0);
        chk("rsvd_hi", hi, 32'h12345678);

        cyc(3'd2, 1'b0, 32'h3, 32'h4, 1'b0);
        cyc(3'd6, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        cyc(3'd1, 1'b1, 32'h7, 32'h7, 1'b0);
        wait_idle("busy_mtlo", 3);
        chk("busy_mtlo_lo", lo, 32'd12);
        chk("busy_mtlo_hi", hi, 32'd0);

        cyc(3'd3, 1'b0, 32'd100, 32'd7, 1'b0);
        idle();
        idle();
        cyc(3'd0, 1'b0, '0, '0, 1'b1);
        chk("rst_abort_busy", {31'd0, busy}, 32'd0);
        chk("rst_abort_hi", hi, 32'h0);
        chk("rst_abort_lo", lo, 32'h0);
        for (int i = 0; i < 12; i++) idle();
        chk("rst_nocommit_lo", lo, 32'h0);
        chk("rst_nocommit_hi", hi, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage multiply/divide unit owning the HI/LO registers.
- Consumes decoded mult/multu/div/divu/mthi/mtlo requests from the E stage and supplies HI/LO to mfhi/mflo.
- Provides busy so the hazard unit can stall any MD-class instruction in D while an operation is in flight.
- Multi-cycle latency is modelled with a down-counter; results commit to HI/LO only on completion.

Parameters:
- MULT_CYCLES, 5, cycles busy is held high for mult/multu (range 1..15).
- DIV_CYCLES, 10, cycles busy is held high for div/divu (range 1..15).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high; clears all state.
- md_op  input  3  request in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- kill  input  1  suppresses md_op this cycle (exception/interrupt taken in M, or E flushed).
- rs_val  input  32  forwarded GRF[rs]; dividend / multiplicand / mthi-mtlo data.
- rt_val  input  32  forwarded GRF[rt]; divisor / multiplier.
- busy  output  1  operation in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending result=0. Reset during an operation aborts it; no late HI/LO commit.
- Accept condition: md_op in {1..6} && !kill && !busy. Requests with busy=1 or kill=1 are ignored and leave no side effect; the stall logic must not issue them.
- mult/multu/div/divu accepted at edge T:
  - Full result is computed from rs_val/rt_val and latched into pending_hi/pending_lo.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES; busy=1 from after edge T.
  - Counter decrements each edge. On the edge where it goes 1->0, pending is written to hi/lo and busy falls.
  - busy is therefore high for exactly N cycles. New hi/lo are visible in the first cycle busy=0.
- hi/lo hold their old values for the whole busy window.
- mthi/mtlo accepted at edge T: hi or lo takes rs_val at T, single cycle, busy stays 0. The other register is unchanged.
- mult: signed 32x32->64, hi=product[63:32], lo=product[31:0]. multu: same, unsigned.
- div: signed, quotient truncated toward zero into lo; remainder into hi with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient into lo, remainder into hi.
- Divide by zero (rt_val=0): the operation still runs DIV_CYCLES with busy high, but hi/lo are left unchanged at completion.
- kill asserted together with a valid md_op: nothing starts. kill has no effect on an operation already in flight; a committed mult/div always completes.
- Reserved op 7: no effect.
- Outputs hi, lo and busy come directly from registers; no combinational path from inputs to outputs.

Decomposition:
- Shared package/header holds:
  - the md_op encodings (MD_NONE..MD_MTLO) as `define constants in the same include file as the instruction decode macros, so the Controller can drive md_op;
  - MULT_CYCLES and DIV_CYCLES default values.
- One natural sub-module, md_arith: purely combinational; takes rs_val, rt_val and op and returns {res_hi, res_lo, div_by_zero}.
- mul_div_unit keeps the counter, busy, pending and HI/LO registers.

Test Plan:
- Reset, then mult with rs=0xFFFFFFFF (-1), rt=0x00000002:
  - busy high for 5 cycles, hi/lo stay 0 throughout;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with rs=0xFFFFFFFF, rt=0x00000002: after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div with rs=0xFFFFFFF9 (-7), rt=0x00000002: busy for 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu by zero after mthi 0x12345678 / mtlo 0x9ABCDEF0:
  - busy for 10 cycles;
  - hi/lo still 0x12345678/0x9ABCDEF0 afterwards.
- Three boundary cases:
  - mult with kill=1: busy never rises, hi/lo unchanged.
  - mtlo issued while busy: ignored.
  - reset asserted at busy cycle 3 of a div: next cycle busy=0, hi=lo=0, and no commit follows.
